// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// default sizing, FSM state encoding and the iteration-counter width.
package bcd_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter covers 0 .. 4*digits-1; never narrower than one bit.
  function automatic int cnt_w(input int digits);
    return (4 * digits > 1) ? $clog2(4 * digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD nibble correction step of reverse double dabble:
// after a right shift, any nibble that reached 8 or more gets 3 taken off.
module bcd_digit_adjust (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd8) ? nib - 4'd3 : nib;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), en/rdy handshake.
// Optional invalid-digit checking is built when BCD2BIN_CHECK_EN is defined.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_d_in,
  output logic [BIN_W-1:0]      bin_d_out,
  output logic                  rdy,
  output logic                  err
);

  localparam int SH_W  = 4 * DIGITS;
  localparam int REG_W = 2 * SH_W;
  localparam int CW    = cnt_w(DIGITS);

  // The binary field is SH_W bits wide so that every bit shifted out of the
  // BCD field is kept; only its low BIN_W bits are reported.
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [REG_W-1:0] sh;
  logic [REG_W-1:0] sh_shr;
  logic [REG_W-1:0] sh_next;
  logic             done;
  logic [BIN_W-1:0] result;

  assign sh_shr = sh >> 1;
  assign sh_next[SH_W-1:0] = sh_shr[SH_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .nib (sh_shr[SH_W + 4*g +: 4]),
      .adj (sh_next[SH_W + 4*g +: 4])
    );
  end

  assign done = (state == SHIFT) && (cnt == CW'(SH_W - 1));

`ifdef BCD2BIN_CHECK_EN
  function automatic logic has_bad_digit(input logic [SH_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic bad_q;
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && en) bad_q <= has_bad_digit(bcd_d_in);
      if (done)                err_q <= bad_q;
    end
  end

  assign result = bad_q ? '0 : BIN_W'(sh_next[SH_W-1:0]);
  assign err    = err_q;
`else
  assign result = BIN_W'(sh_next[SH_W-1:0]);
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      bin_d_out <= '0;
      rdy       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            sh    <= {bcd_d_in, {SH_W{1'b0}}};
            cnt   <= '0;
            rdy   <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sh  <= sh_next;
          cnt <= cnt + CW'(1);
          if (done) begin
            bin_d_out <= result;
            rdy       <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: vector table, handshake corner cases,
// reset abort and a bin2BCD round trip, all scored through an expectation queue.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] bcd_d_in;
  logic [13:0] bin_d_out;
  logic        rdy;
  logic        err;

  bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bcd_d_in  (bcd_d_in),
    .bin_d_out (bin_d_out),
    .rdy       (rdy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference bin2BCD used for the round trip.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int          t;
    b = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      b[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // Monitor: scores every completion and the busy length before it.
  logic rst_q = 1'b0;
  logic rdy_prev = 1'b1;
  int   busy = 0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      busy = 0;
    end else if (rdy === 1'b0) begin
      busy++;
    end else if (rdy === 1'b1 && rdy_prev === 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious completion: bin_d_out=%0d, expected no conversion", bin_d_out);
      end else begin
        e = sb.pop_front();
        check("result", int'(bin_d_out), int'(e.bin));
        check("err", int'(err), int'(e.err));
        check("busy cycles", busy, 16);
      end
      busy = 0;
    end else begin
      busy = 0;
    end
    rdy_prev = rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int t;
    t = 0;
    while (rdy !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    if (rdy !== 1'b1) check("rdy timeout", int'(rdy), 1);
  endtask

  task automatic start(input logic [15:0] b, input logic [13:0] eb, input logic ee,
                       input bit score);
    exp_t e;
    wait_rdy();
    bcd_d_in = b;
    en       = 1'b1;
    if (score) begin
      e.bin = eb;
      e.err = ee;
      sb.push_back(e);
    end
    tick();
    en = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    if (sb.size() != 0) check("drain timeout", sb.size(), 0);
    tick();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'h0042, 14'd42};
    vecs[1] = '{16'h0000, 14'd0};
    vecs[2] = '{16'h1234, 14'd1234};
    vecs[3] = '{16'h9999, 14'd9999};
    vecs[4] = '{16'h0001, 14'd1};
    vecs[5] = '{16'h1000, 14'd1000};
    vecs[6] = '{16'h0099, 14'd99};
    vecs[7] = '{16'h5678, 14'd5678};
    vecs[8] = '{16'h0800, 14'd800};
    vecs[9] = '{16'h9000, 14'd9000};

    rst = 1'b1;
    en = 1'b0;
    bcd_d_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset rdy", int'(rdy), 1);
    check("reset bin_d_out", int'(bin_d_out), 0);
    check("reset err", int'(err), 0);

    // Idle with changing inputs but no en: nothing moves.
    for (int i = 0; i < 5; i++) begin
      bcd_d_in = 16'($urandom);
      repeat (3) tick();
      check("idle rdy", int'(rdy), 1);
      check("idle bin_d_out", int'(bin_d_out), 0);
    end

    for (int i = 0; i < 10; i++) begin
      start(vecs[i].bcd, vecs[i].bin, 1'b0, 1'b1);
      check("rdy low after start", int'(rdy), 0);
      drain();
      check("stable after completion", int'(bin_d_out), int'(vecs[i].bin));
    end

    // en pulsed mid-conversion with different data must be ignored.
    start(16'h0042, 14'd42, 1'b0, 1'b1);
    repeat (5) tick();
    bcd_d_in = 16'h0777;
    en = 1'b1;
    tick();
    en = 1'b0;
    drain();
    repeat (20) tick();
    check("no extra conversion rdy", int'(rdy), 1);
    check("no extra conversion bin", int'(bin_d_out), 42);

    // en held high: back-to-back, second load on the edge after rdy rises.
    begin
      exp_t e;
      wait_rdy();
      bcd_d_in = 16'h0321;
      en = 1'b1;
      e.bin = 14'd321; e.err = 1'b0; sb.push_back(e);
      tick();
      bcd_d_in = 16'h0654;
      e.bin = 14'd654; e.err = 1'b0; sb.push_back(e);
      wait_rdy();
      tick();
      en = 1'b0;
      check("back-to-back restart rdy", int'(rdy), 0);
      drain();
    end

    // Reset on the 8th SHIFT edge aborts without writing a result.
    start(16'h0321, 14'd0, 1'b0, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort rdy", int'(rdy), 1);
    check("abort bin_d_out", int'(bin_d_out), 0);
    check("abort err", int'(err), 0);
    repeat (20) tick();
    check("abort stays idle", int'(rdy), 1);
    check("abort no result", int'(bin_d_out), 0);
    start(16'h0500, 14'd500, 1'b0, 1'b1);
    drain();

    // rst and en on the same edge: rst wins.
    rst = 1'b1;
    en = 1'b1;
    bcd_d_in = 16'h0077;
    tick();
    rst = 1'b0;
    en = 1'b0;
    check("rst beats en rdy", int'(rdy), 1);
    check("rst beats en bin", int'(bin_d_out), 0);
    repeat (2) tick();

`ifdef BCD2BIN_CHECK_EN
    start(16'h00A0, 14'd0, 1'b1, 1'b1);
    drain();
    start(16'h0099, 14'd99, 1'b0, 1'b1);
    drain();
`endif

    // Round trip: adder sum -> bin2BCD -> converter.
    for (int s = 0; s < 32; s++) begin
      start(to_bcd(s), 14'(s), 1'b0, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
